// File: rtl/tq_premute_if.sv
// Handshake bundle between the TQ block scheduler,
// the permutation sequencer and the transform datapath.
interface tq_premute_if #(
  parameter int CNT_W = 5
);
  logic             start;
  logic [1:0]       size;
  logic             inverse_in;
  logic             ds_ready;
  logic             busy;
  logic             row_valid;
  logic [CNT_W-1:0] row_idx;
  logic             pass;
  logic             en_8;
  logic             en_16;
  logic             en_32;
  logic             inverse;
  logic             done;

  modport master (
    output start,
    output size,
    output inverse_in,
    output ds_ready,
    input  busy,
    input  row_valid,
    input  row_idx,
    input  pass,
    input  en_8,
    input  en_16,
    input  en_32,
    input  inverse,
    input  done
  );

  modport slave (
    input  start,
    input  size,
    input  inverse_in,
    input  ds_ready,
    output busy,
    output row_valid,
    output row_idx,
    output pass,
    output en_8,
    output en_16,
    output en_32,
    output inverse,
    output done
  );
endinterface

// File: rtl/tq_premute_ctrl.sv
// TQ permutation-stage sequencer: issues row slots for
// a row pass and a column pass with registered enables.
module tq_premute_ctrl #(
  parameter int GAP_CYCLES = 4,
  parameter int CNT_W      = 5
) (
  input  logic         clk,
  input  logic         rst,
  tq_premute_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] row_idx_q, row_idx_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [3:0]       gap_q, gap_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             pass_q, pass_d;
  logic             en8_q, en8_d;
  logic             en16_q, en16_d;
  logic             en32_q, en32_d;
  logic             inv_q, inv_d;
  logic             done_q, done_d;

  localparam logic [3:0] GAP_LAST =
    4'(GAP_CYCLES - 1);

  function automatic logic [CNT_W-1:0]
    last_row(input logic [1:0] sz);
    logic [CNT_W-1:0] r;
    unique case (sz)
      2'b00:   r = CNT_W'(3);
      2'b01:   r = CNT_W'(7);
      2'b10:   r = CNT_W'(15);
      default: r = CNT_W'(31);
    endcase
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    last_d    = last_q;
    gap_d     = gap_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    pass_d    = pass_q;
    en8_d     = en8_q;
    en16_d    = en16_q;
    en32_d    = en32_q;
    inv_d     = inv_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RUN;
          busy_d    = 1'b1;
          valid_d   = 1'b1;
          pass_d    = 1'b0;
          row_idx_d = '0;
          last_d    = last_row(bus.size);
          en8_d     = |bus.size;
          en16_d    = bus.size[1];
          en32_d    = &bus.size;
          inv_d     = bus.inverse_in;
        end
      end
      RUN: begin
        if (bus.ds_ready) begin
          if (row_idx_q == last_q) begin
            valid_d   = 1'b0;
            row_idx_d = '0;
            if (pass_q) begin
              // Block ends: drop busy and the
              // block-wide controls together.
              state_d = DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              pass_d  = 1'b0;
              en8_d   = 1'b0;
              en16_d  = 1'b0;
              en32_d  = 1'b0;
              inv_d   = 1'b0;
            end else begin
              state_d = GAP;
              gap_d   = '0;
            end
          end else begin
            row_idx_d = row_idx_q + CNT_W'(1);
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d   = RUN;
          pass_d    = 1'b1;
          valid_d   = 1'b1;
          row_idx_d = '0;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      row_idx_q <= '0;
      last_q    <= '0;
      gap_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      pass_q    <= 1'b0;
      en8_q     <= 1'b0;
      en16_q    <= 1'b0;
      en32_q    <= 1'b0;
      inv_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      last_q    <= last_d;
      gap_q     <= gap_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      pass_q    <= pass_d;
      en8_q     <= en8_d;
      en16_q    <= en16_d;
      en32_q    <= en32_d;
      inv_q     <= inv_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.row_valid = valid_q;
  assign bus.row_idx   = row_idx_q;
  assign bus.pass      = pass_q;
  assign bus.en_8      = en8_q;
  assign bus.en_16     = en16_q;
  assign bus.en_32     = en32_q;
  assign bus.inverse   = inv_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_tq_premute_ctrl.sv
// Directed bench for the TQ permutation sequencer.
// Outputs are sampled 1ns after each rising edge.
module tb_tq_premute_ctrl;

  logic clk;
  logic rst;
  int   n_err;
  int   n_chk;

  tq_premute_if #(.CNT_W(5)) bus ();

  tq_premute_ctrl #(
    .GAP_CYCLES(4),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  wire [12:0] outs = {bus.busy, bus.row_valid,
    bus.row_idx, bus.pass, bus.en_8, bus.en_16,
    bus.en_32, bus.inverse, bus.done};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one block from start to the done cycle;
  // returns with the done cycle being sampled.
  task automatic run_block(input logic [1:0] sz,
                           input logic inv,
                           input int st_a,
                           input int st_b,
                           input int exp_len,
                           input bit poke);
    int n;
    int cyc;
    int hold;
    logic e8, e16, e32;
    n   = 4 << sz;
    e8  = (sz != 2'b00);
    e16 = (sz == 2'b10) || (sz == 2'b11);
    e32 = (sz == 2'b11);
    bus.ds_ready   = 1'b1;
    bus.start      = 1'b1;
    bus.size       = sz;
    bus.inverse_in = inv;
    tick();
    bus.start      = 1'b0;
    bus.size       = ~sz;
    bus.inverse_in = ~inv;
    cyc = 1;
    chk("busy_rise", bus.busy, 1);
    chk("en_8", bus.en_8, e8);
    chk("en_16", bus.en_16, e16);
    chk("en_32", bus.en_32, e32);
    chk("inverse", bus.inverse, inv);
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < n; r++) begin
        hold = 0;
        if (p == 0 && (r == st_a || r == st_b))
          hold = 2;
        for (int s = 0; s <= hold; s++) begin
          chk("row_valid", bus.row_valid, 1);
          chk("row_idx", bus.row_idx, r);
          chk("pass", bus.pass, p);
          chk("no_done", bus.done, 0);
          chk("en_hold",
              {bus.en_8, bus.en_16, bus.en_32,
               bus.inverse},
              {e8, e16, e32, inv});
          bus.ds_ready = (s < hold) ? 1'b0 : 1'b1;
          bus.start = (poke && p == 0 && r == 1);
          if (bus.start) bus.size = 2'b11;
          tick();
          cyc++;
        end
      end
      bus.start = 1'b0;
      if (p == 0) begin
        bus.ds_ready = 1'b0;
        for (int g = 0; g < 4; g++) begin
          chk("gap_valid", bus.row_valid, 0);
          chk("gap_busy", bus.busy, 1);
          tick();
          cyc++;
        end
        bus.ds_ready = 1'b1;
      end
    end
    chk("done", bus.done, 1);
    chk("done_busy", bus.busy, 0);
    chk("done_valid", bus.row_valid, 0);
    chk("done_en", {bus.en_8, bus.en_16,
        bus.en_32, bus.inverse}, 0);
    chk("block_len", cyc, exp_len);
  endtask

  initial begin
    int cyc;
    n_err = 0;
    n_chk = 0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.size       = 2'b00;
    bus.inverse_in = 1'b0;
    bus.ds_ready   = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_outs", outs, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_outs", outs, 0);
    end

    run_block(2'b01, 1'b0, -1, -1, 21, 1'b0);
    tick();
    chk("idle_after_8", outs, 0);

    run_block(2'b11, 1'b1, 5, 31, 73, 1'b0);
    tick();
    chk("idle_after_32", outs, 0);

    run_block(2'b00, 1'b0, -1, -1, 13, 1'b1);
    // start in the done cycle is ignored
    bus.start = 1'b1;
    bus.size  = 2'b01;
    tick();
    chk("b2b_ign_busy", bus.busy, 0);
    chk("b2b_ign_valid", bus.row_valid, 0);
    chk("b2b_ign_done", bus.done, 0);
    tick();
    bus.start = 1'b0;
    chk("b2b_busy", bus.busy, 1);
    chk("b2b_row", {bus.row_valid, bus.row_idx}, 6'h20);
    chk("b2b_en8", bus.en_8, 1);
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("b2b_len", cyc, 21);
    tick();

    bus.start      = 1'b1;
    bus.size       = 2'b10;
    bus.inverse_in = 1'b0;
    bus.ds_ready   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 23; i++) tick();
    chk("mid_pass", bus.pass, 1);
    chk("mid_row", bus.row_idx, 3);
    chk("mid_en16", bus.en_16, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst", outs, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_done", outs, 0);
    end
    rst = 1'b0;
    tick();
    chk("post_rst_idle", outs, 0);
    run_block(2'b10, 1'b0, -1, -1, 37, 1'b0);
    tick();
    chk("final_idle", outs, 0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
